onchip_memory_dp: RTL and testbench

- Parametrised true dual-port on-chip RAM with two independent Avalon-MM slaves (s1, s2) on one clock.
- Successor to the single-port 32-bit on-chip memory: width, depth and read latency are configurable, and it adds pipelined readdatavalid, waitrequest backpressure, a post-reset zero-scrub engine and write-collision arbitration.
- Sits on the system interconnect as program/data memory shared by the CPU and a DMA master.

---
 rtl/onchip_memory_dp.sv | 214 +++++++++++++++++++++
 tb/tb_onchip_memory_dp.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_memory_dp.sv
// True dual-port on-chip RAM with two Avalon-MM slaves on one clock.
// Adds a post-reset zero scrub, pipelined readdatavalid and dual-write collision arbitration.
module onchip_memory_dp #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 14,
    parameter int DEPTH        = 8960,
    parameter int READ_LATENCY = 1,
    parameter int SCRUB_EN     = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    input  logic                    clken,
    input  logic [ADDR_WIDTH-1:0]   s1_address,
    input  logic                    s1_chipselect,
    input  logic                    s1_read,
    input  logic                    s1_write,
    input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
    input  logic [DATA_WIDTH-1:0]   s1_writedata,
    output logic [DATA_WIDTH-1:0]   s1_readdata,
    output logic                    s1_readdatavalid,
    output logic                    s1_waitrequest,
    input  logic [ADDR_WIDTH-1:0]   s2_address,
    input  logic                    s2_chipselect,
    input  logic                    s2_read,
    input  logic                    s2_write,
    input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
    input  logic [DATA_WIDTH-1:0]   s2_writedata,
    output logic [DATA_WIDTH-1:0]   s2_readdata,
    output logic                    s2_readdatavalid,
    output logic                    s2_waitrequest,
    output logic                    init_done,
    output logic                    collision
);

    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AW1   = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = AW1'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        SCRUB = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   scrub_cnt;
    logic                    en;
    logic                    run;
    logic                    scrub_we;
    logic                    wait_all;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    // Per-port views so both slaves share one set of decode logic.
    logic [ADDR_WIDTH-1:0]   p_addr  [2];
    logic [BE_W-1:0]         p_be    [2];
    logic [DATA_WIDTH-1:0]   p_wdata [2];
    logic [1:0]              p_cs;
    logic [1:0]              p_rd;
    logic [1:0]              p_wr;

    logic [1:0]              in_range;
    logic [1:0]              acc;
    logic [1:0]              wr_acc;
    logic [1:0]              rd_acc;
    logic                    coll_now;
    logic [DATA_WIDTH-1:0]   rd_word [2];

    logic                    we_a;
    logic                    we_b;
    logic [IDX_W-1:0]        a_idx;
    logic [IDX_W-1:0]        b_idx;
    logic [BE_W-1:0]         a_be;
    logic [DATA_WIDTH-1:0]   a_wdata;

    logic [1:0]              stg_v;
    logic [DATA_WIDTH-1:0]   stg_d   [2];
    logic [1:0]              rdv_q;
    logic [DATA_WIDTH-1:0]   rdata_q [2];

    assign en       = clken & ~reset_req;
    assign run      = (state == RUN);
    assign scrub_we = (state == SCRUB) && en && (SCRUB_EN != 0);
    assign wait_all = ~(run & en);

    assign s1_waitrequest = wait_all;
    assign s2_waitrequest = wait_all;

    assign p_addr[0]  = s1_address;
    assign p_addr[1]  = s2_address;
    assign p_be[0]    = s1_byteenable;
    assign p_be[1]    = s2_byteenable;
    assign p_wdata[0] = s1_writedata;
    assign p_wdata[1] = s2_writedata;
    assign p_cs       = {s2_chipselect, s1_chipselect};
    assign p_rd       = {s2_read, s1_read};
    assign p_wr       = {s2_write, s1_write};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= SCRUB;
            scrub_cnt <= '0;
            init_done <= 1'b0;
        end else if (state == SCRUB) begin
            if (SCRUB_EN == 0) begin
                state     <= RUN;
                init_done <= 1'b1;
            end else if (en) begin
                if (scrub_cnt == LAST_ADDR) begin
                    state     <= RUN;
                    init_done <= 1'b1;
                    scrub_cnt <= '0;
                end else begin
                    scrub_cnt <= scrub_cnt + 1'b1;
                end
            end
        end
    end

    // A port doing read and write together is treated as a write only.
    always_comb begin
        in_range = '0;
        acc      = '0;
        wr_acc   = '0;
        rd_acc   = '0;
        for (int p = 0; p < 2; p++) begin
            in_range[p] = ({1'b0, p_addr[p]} < DEPTH_EXT);
            acc[p]      = p_cs[p] & (p_rd[p] | p_wr[p]) & ~wait_all;
            wr_acc[p]   = acc[p] & p_wr[p];
            rd_acc[p]   = acc[p] & p_rd[p] & ~p_wr[p];
        end
    end

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_word[p] = '0;
            if (in_range[p]) begin
                rd_word[p] = mem[p_addr[p][IDX_W-1:0]];
            end
        end
    end

    // Same-address dual write: s1 wins whole, s2 is dropped. An all-zero
    // byteenable on either side is a no-op write and never collides.
    assign coll_now = wr_acc[0] & wr_acc[1] & in_range[0] & in_range[1] &
                      (p_addr[0] == p_addr[1]) & (|p_be[0]) & (|p_be[1]);

    assign we_a    = scrub_we | (wr_acc[0] & in_range[0]);
    assign we_b    = wr_acc[1] & in_range[1] & ~coll_now;
    assign a_idx   = scrub_we ? scrub_cnt[IDX_W-1:0] : p_addr[0][IDX_W-1:0];
    assign b_idx   = p_addr[1][IDX_W-1:0];
    assign a_be    = scrub_we ? {BE_W{1'b1}} : p_be[0];
    assign a_wdata = scrub_we ? '0 : p_wdata[0];

    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (we_a && a_be[b]) begin
                mem[a_idx][8*b +: 8] <= a_wdata[8*b +: 8];
            end
            if (we_b && p_be[1][b]) begin
                mem[b_idx][8*b +: 8] <= p_wdata[1][8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            collision <= 1'b0;
        end else if (coll_now) begin
            collision <= 1'b1;
        end
    end

    // Stage registers freeze while en is low; the valid output is a single
    // pulse, so a result already presented is never repeated across a freeze.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stg_v <= '0;
            rdv_q <= '0;
            for (int p = 0; p < 2; p++) begin
                stg_d[p]   <= '0;
                rdata_q[p] <= '0;
            end
        end else if (en) begin
            for (int p = 0; p < 2; p++) begin
                if (READ_LATENCY == 1) begin
                    rdv_q[p] <= rd_acc[p];
                    if (rd_acc[p]) begin
                        rdata_q[p] <= rd_word[p];
                    end
                end else begin
                    stg_v[p] <= rd_acc[p];
                    if (rd_acc[p]) begin
                        stg_d[p] <= rd_word[p];
                    end
                    rdv_q[p] <= stg_v[p];
                    if (stg_v[p]) begin
                        rdata_q[p] <= stg_d[p];
                    end
                end
            end
        end else begin
            rdv_q <= '0;
        end
    end

    assign s1_readdata      = rdata_q[0];
    assign s2_readdata      = rdata_q[1];
    assign s1_readdatavalid = rdv_q[0];
    assign s2_readdatavalid = rdv_q[1];

endmodule

// File: tb/tb_onchip_memory_dp.sv
// Bench for onchip_memory_dp: READ_LATENCY 1 and 2 instances share stimulus and
// are checked every cycle against a queue-based memory model plus literal checks.
module tb_onchip_memory_dp;

    localparam int D = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reset_req = 1'b0;
    logic        clken = 1'b1;
    logic [4:0]  s1_address = '0, s2_address = '0;
    logic        s1_chipselect = 1'b0, s2_chipselect = 1'b0;
    logic        s1_read = 1'b0, s2_read = 1'b0;
    logic        s1_write = 1'b0, s2_write = 1'b0;
    logic [3:0]  s1_byteenable = '0, s2_byteenable = '0;
    logic [31:0] s1_writedata = '0, s2_writedata = '0;

    // index: 0 = RL1 s1, 1 = RL1 s2, 2 = RL2 s1, 3 = RL2 s2
    logic [31:0] rdat [4];
    logic        rdv  [4];
    logic        wreq [4];
    logic        idone [2];
    logic        coll  [2];

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 0;
    int cnt_rl1 = 0;
    int cnt_rl2 = 0;

    always #5 clk = ~clk;

    onchip_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(D), .READ_LATENCY(1), .SCRUB_EN(1)) u1 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(rdat[0]), .s1_readdatavalid(rdv[0]), .s1_waitrequest(wreq[0]),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(rdat[1]), .s2_readdatavalid(rdv[1]), .s2_waitrequest(wreq[1]),
        .init_done(idone[0]), .collision(coll[0])
    );

    onchip_memory_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(D), .READ_LATENCY(2), .SCRUB_EN(1)) u2 (
        .clk(clk), .reset(reset), .reset_req(reset_req), .clken(clken),
        .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
        .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
        .s1_readdata(rdat[2]), .s1_readdatavalid(rdv[2]), .s1_waitrequest(wreq[2]),
        .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read),
        .s2_write(s2_write), .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata),
        .s2_readdata(rdat[3]), .s2_readdatavalid(rdv[3]), .s2_waitrequest(wreq[3]),
        .init_done(idone[1]), .collision(coll[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mem_m [D];
    bit          run_m = 0;
    int          scnt_m = 0;
    bit          coll_m = 0;
    logic [31:0] qd [4][$];
    int          qc [4][$];
    bit          exp_rdv [4];
    logic [31:0] exp_dat [4];
    bit          racc [2];
    logic [31:0] rword [2];
    bit          wacc0, wacc1, mcoll;

    function automatic logic [31:0] bemask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) begin
            exp_rdv[i] = 0;
            exp_dat[i] = '0;
        end
    end

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            run_m  = 0;
            scnt_m = 0;
            coll_m = 0;
            for (int i = 0; i < 4; i++) begin
                qd[i].delete();
                qc[i].delete();
                exp_rdv[i] = 0;
                exp_dat[i] = '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) exp_rdv[i] = 0;
            racc[0] = 0;
            racc[1] = 0;
            if (clken && !reset_req) begin
                if (!run_m) begin
                    mem_m[scnt_m] = '0;
                    scnt_m++;
                    if (scnt_m == D) run_m = 1;
                end else begin
                    racc[0]  = s1_chipselect && s1_read && !s1_write;
                    racc[1]  = s2_chipselect && s2_read && !s2_write;
                    rword[0] = (s1_address < D) ? mem_m[s1_address] : 32'h0;
                    rword[1] = (s2_address < D) ? mem_m[s2_address] : 32'h0;
                    wacc0 = s1_chipselect && s1_write;
                    wacc1 = s2_chipselect && s2_write;
                    mcoll = wacc0 && wacc1 && (s1_address == s2_address) && (s1_address < D) &&
                            (s1_byteenable != 0) && (s2_byteenable != 0);
                    if (mcoll) coll_m = 1;
                    if (wacc0 && s1_address < D)
                        mem_m[s1_address] = (mem_m[s1_address] & ~bemask(s1_byteenable)) |
                                            (s1_writedata & bemask(s1_byteenable));
                    if (wacc1 && s2_address < D && !mcoll)
                        mem_m[s2_address] = (mem_m[s2_address] & ~bemask(s2_byteenable)) |
                                            (s2_writedata & bemask(s2_byteenable));
                end
                for (int i = 0; i < 4; i++) begin
                    for (int k = 0; k < qc[i].size(); k++) qc[i][k] = qc[i][k] - 1;
                    if (racc[i % 2]) begin
                        qd[i].push_back(rword[i % 2]);
                        qc[i].push_back((i < 2) ? 0 : 1);
                    end
                    if (qc[i].size() > 0 && qc[i][0] == 0) begin
                        exp_rdv[i] = 1;
                        exp_dat[i] = qd[i].pop_front();
                        void'(qc[i].pop_front());
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (started) begin
            for (int i = 0; i < 4; i++) begin
                check($sformatf("waitrequest[%0d]", i), wreq[i],
                      reset || !run_m || !(clken && !reset_req));
                check($sformatf("readdatavalid[%0d]", i), rdv[i], exp_rdv[i]);
                check($sformatf("readdata[%0d]", i), rdat[i], exp_dat[i]);
            end
            for (int j = 0; j < 2; j++) begin
                check($sformatf("init_done[%0d]", j), idone[j], run_m);
                check($sformatf("collision[%0d]", j), coll[j], coll_m);
            end
        end
        if (rdv[0]) cnt_rl1++;
        if (rdv[2]) cnt_rl2++;
    end

    // ---------------- driver tasks ----------------
    task automatic set_s1(input bit c, input bit r, input bit w, input logic [4:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        s1_chipselect = c; s1_read = r; s1_write = w;
        s1_address = a; s1_byteenable = be; s1_writedata = d;
    endtask

    task automatic set_s2(input bit c, input bit r, input bit w, input logic [4:0] a,
                          input logic [3:0] be, input logic [31:0] d);
        s2_chipselect = c; s2_read = r; s2_write = w;
        s2_address = a; s2_byteenable = be; s2_writedata = d;
    endtask

    task automatic idle();
        set_s1(0, 0, 0, 5'd0, 4'h0, 32'h0);
        set_s2(0, 0, 0, 5'd0, 4'h0, 32'h0);
    endtask

    // Hold the current request until an edge with waitrequest low takes it.
    task automatic accept();
        bit w;
        int t;
        t = 0;
        do begin
            @(negedge clk);
            w = wreq[0];
            @(posedge clk);
            #1;
            t++;
        end while (w && t < 50);
        check("accept_timeout", {31'b0, w}, 32'h0);
    endtask

    task automatic gather(input int p, input logic [31:0] exp, input string name);
        bit g1, g2;
        logic [31:0] v1, v2;
        g1 = 0; g2 = 0; v1 = 'x; v2 = 'x;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (!g1 && rdv[p-1]) begin g1 = 1; v1 = rdat[p-1]; end
            if (!g2 && rdv[p+1]) begin g2 = 1; v2 = rdat[p+1]; end
        end
        @(posedge clk);
        #1;
        check({name, "_rl1_valid"}, {31'b0, g1}, 32'h1);
        check({name, "_rl1_data"}, v1, exp);
        check({name, "_rl2_valid"}, {31'b0, g2}, 32'h1);
        check({name, "_rl2_data"}, v2, exp);
    endtask

    task automatic read_check(input int p, input logic [4:0] a, input logic [31:0] exp,
                              input string name);
        if (p == 1) set_s1(1, 1, 0, a, 4'h0, 32'h0);
        else        set_s2(1, 1, 0, a, 4'h0, 32'h0);
        accept();
        idle();
        gather(p, exp, name);
    endtask

    task automatic count_scrub(input bit pause, output int n);
        n = 0;
        while (!idone[0] && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (pause && n == 4) clken = 1'b0;
            if (pause && n == 7) clken = 1'b1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int c1, c2;
        @(posedge clk);
        #1;
        started = 1;
        check("reset_waitrequest", {31'b0, wreq[0]}, 32'h1);
        check("reset_init_done", {31'b0, idone[0]}, 32'h0);
        check("reset_readdata", rdat[0], 32'h0);
        reset = 1'b0;

        // scrub takes exactly DEPTH en cycles, then every word reads as zero
        count_scrub(0, n);
        check("scrub_cycles", n, 16);
        for (int a = 0; a < D; a++) begin
            set_s1(1, 1, 0, 5'(a), 4'h0, 32'h0);
            accept();
        end
        idle();
        repeat (3) @(posedge clk);
        #1;
        read_check(1, 5'd9, 32'h0, "scrub_zero");

        // partial byte write over a preloaded word
        set_s1(1, 0, 1, 5'd3, 4'hF, 32'h11223344);
        accept();
        set_s1(1, 0, 1, 5'd3, 4'b0101, 32'hDEADBEEF);
        accept();
        idle();
        read_check(1, 5'd3, 32'h11AD33EF, "partial_write");

        // same-address dual write: s1 wins, sticky collision
        set_s1(1, 0, 1, 5'd5, 4'hF, 32'hAAAAAAAA);
        set_s2(1, 0, 1, 5'd5, 4'hF, 32'h55555555);
        accept();
        idle();
        read_check(1, 5'd5, 32'hAAAAAAAA, "collision_data");
        check("collision_flag", {31'b0, coll[0]}, 32'h1);
        repeat (5) @(posedge clk);
        #1;
        read_check(2, 5'd5, 32'hAAAAAAAA, "collision_data_s2");
        check("collision_sticky", {31'b0, coll[1]}, 32'h1);

        // cross-port read-before-write
        set_s1(1, 0, 1, 5'd7, 4'hF, 32'h12345678);
        set_s2(1, 1, 0, 5'd7, 4'h0, 32'h0);
        accept();
        idle();
        gather(2, 32'h0, "rbw_old");
        read_check(2, 5'd7, 32'h12345678, "rbw_new");

        // read+write on one port is a write with no readdatavalid
        set_s1(1, 1, 1, 5'd8, 4'hF, 32'hCAFEF00D);
        accept();
        idle();
        repeat (3) @(posedge clk);
        #1;
        read_check(1, 5'd8, 32'hCAFEF00D, "rw_as_write");

        // streaming reads with a 2-cycle reset_req freeze
        c1 = cnt_rl1;
        c2 = cnt_rl2;
        fork
            begin
                for (int a = 0; a < 4; a++) begin
                    set_s1(1, 1, 0, 5'(a), 4'h0, 32'h0);
                    accept();
                end
                idle();
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                reset_req = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                reset_req = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("stream_pulses_rl1", cnt_rl1 - c1, 4);
        check("stream_pulses_rl2", cnt_rl2 - c2, 4);
        read_check(1, 5'd3, 32'h11AD33EF, "freeze_mem_intact");

        // out-of-range: write dropped (no aliasing), read returns zero
        set_s1(1, 0, 1, 5'd20, 4'hF, 32'hFFFFFFFF);
        accept();
        idle();
        read_check(1, 5'd20, 32'h0, "oor_read");
        read_check(2, 5'd4, 32'h0, "oor_no_alias");

        // reset mid-scrub restarts the counter; clken pause stretches it
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("midscrub_init_low", {31'b0, idone[0]}, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        count_scrub(1, n);
        check("rescrub_cycles", n, 19);
        check("collision_cleared", {31'b0, coll[0]}, 32'h0);
        read_check(1, 5'd5, 32'h0, "rescrub_zero");

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
